// File: rtl/led_inten_seq_if.sv
// Sample-stream and result bundle for the LED-bar intensity engine.
// The master drives samples in; the slave returns RMS, peak-hold and thermometer.
interface led_inten_seq_if;
  logic        vld;
  logic [15:0] lft_chnnl;
  logic [15:0] rght_chnnl;
  logic [15:0] inten;
  logic [15:0] peak;
  logic [7:0]  LED;
  logic        busy;
  logic        done;
  logic        ovr;

  modport master (
    output vld, lft_chnnl, rght_chnnl,
    input  inten, peak, LED, busy, done, ovr
  );

  modport slave (
    input  vld, lft_chnnl, rght_chnnl,
    output inten, peak, LED, busy, done, ovr
  );
endinterface

// File: rtl/led_inten_seq.sv
// Sequenced RMS of one L/R sample pair via one shared 16x16 multiplier and a
// bit-serial square root, followed by peak-hold/decay and an 8-segment thermometer.
module led_inten_seq #(
  parameter logic [15:0] STEP        = 16'h0200,
  parameter int unsigned HOLD_SMPLS  = 8,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input logic            clk,
  input logic            rst_n,
  led_inten_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSql, StSqr, StRoot, StUpd} state_e;

  state_e      state_q;
  logic [15:0] mag_l_q, mag_r_q;
  logic [31:0] acc_q, mean_q;
  logic [15:0] root_q;
  logic [3:0]  bit_q;
  logic [7:0]  hold_cnt_q;
  logic [15:0] inten_q, peak_q;
  logic [7:0]  led_q;
  logic        done_q, ovr_q;

  logic [15:0] mul_a, mul_b, trial;
  logic [31:0] product;
  logic [32:0] sum;
  logic [15:0] decay, peak_next;
  logic [7:0]  hold_next, led_next;

  // -32768 maps to 0x8000 because the negation wraps in 16 bits.
  function automatic logic [15:0] mag(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  assign trial = root_q | (16'd1 << bit_q);

  always_comb begin
    mul_a = 16'd0;
    mul_b = 16'd0;
    unique case (state_q)
      StSql: begin
        mul_a = mag_l_q;
        mul_b = mag_l_q;
      end
      StSqr: begin
        mul_a = mag_r_q;
        mul_b = mag_r_q;
      end
      StRoot: begin
        mul_a = trial;
        mul_b = trial;
      end
      default: ;
    endcase
  end

  assign product = 32'(mul_a) * 32'(mul_b);
  assign sum     = {1'b0, acc_q} + {1'b0, product};

  always_comb begin
    decay = peak_q >> DECAY_SHIFT;
    if (decay == 16'd0) decay = 16'd1;
    peak_next = peak_q;
    hold_next = hold_cnt_q;
    if (root_q >= peak_q) begin
      peak_next = root_q;
      hold_next = 8'd0;
    end else if (32'(hold_cnt_q) < HOLD_SMPLS) begin
      hold_next = hold_cnt_q + 8'd1;
    end else begin
      peak_next = (peak_q > decay) ? (peak_q - decay) : 16'd0;
    end
  end

  always_comb begin
    led_next    = 8'd0;
    led_next[0] = (peak_next != 16'd0);
    for (int i = 1; i < 8; i++) begin
      led_next[i] = ({16'd0, peak_next} > (i * 32'(STEP)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mag_l_q    <= 16'd0;
      mag_r_q    <= 16'd0;
      acc_q      <= 32'd0;
      mean_q     <= 32'd0;
      root_q     <= 16'd0;
      bit_q      <= 4'd0;
      hold_cnt_q <= 8'd0;
      inten_q    <= 16'd0;
      peak_q     <= 16'd0;
      led_q      <= 8'd0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Samples arriving mid-computation are dropped and flagged.
      ovr_q  <= bus.vld && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (bus.vld) begin
            mag_l_q <= mag(bus.lft_chnnl);
            mag_r_q <= mag(bus.rght_chnnl);
            state_q <= StSql;
          end
        end
        StSql: begin
          acc_q   <= product;
          state_q <= StSqr;
        end
        StSqr: begin
          mean_q  <= sum[32:1];
          root_q  <= 16'd0;
          bit_q   <= 4'd15;
          state_q <= StRoot;
        end
        StRoot: begin
          if (product <= mean_q) root_q <= trial;
          if (bit_q == 4'd0) state_q <= StUpd;
          else               bit_q   <= bit_q - 4'd1;
        end
        StUpd: begin
          inten_q    <= root_q;
          peak_q     <= peak_next;
          hold_cnt_q <= hold_next;
          led_q      <= led_next;
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inten = inten_q;
  assign bus.peak  = peak_q;
  assign bus.LED   = led_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = done_q;
  assign bus.ovr   = ovr_q;

endmodule

// File: tb/tb_led_inten_seq.sv
// Bench for led_inten_seq: cycle-level reference model compared every cycle,
// directed cases pinned with literal values, then randomized traffic.
module tb_led_inten_seq;
  localparam int unsigned HOLD = 4;
  localparam int unsigned DSH  = 3;
  localparam logic [15:0] STP  = 16'h0200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_inten_seq_if bus ();

  led_inten_seq #(
    .STEP       (STP),
    .HOLD_SMPLS (HOLD),
    .DECAY_SHIFT(DSH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since acceptance, result computed with plain arithmetic.
  int          m_cnt   = 0;
  logic [15:0] m_res   = '0;
  logic [15:0] m_inten = '0;
  logic [15:0] m_peak  = '0;
  int          m_hold  = 0;
  logic [7:0]  m_led   = '0;
  logic        m_done  = 1'b0;
  logic        m_ovr   = 1'b0;
  longint      m_l, m_r, m_d;

  function automatic logic [15:0] isqrt(input longint m);
    longint r;
    r = longint'($floor($sqrt(real'(m))));
    while (r * r > m) r--;
    while ((r + 1) * (r + 1) <= m) r++;
    return 16'(r);
  endfunction

  function automatic logic [7:0] therm(input logic [15:0] p);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (int'(p) > i * int'(STP));
    return t;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_res = '0; m_inten = '0; m_peak = '0; m_hold = 0;
      m_led = '0; m_done = 1'b0; m_ovr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_ovr  = 1'b0;
      if (m_cnt == 0) begin
        if (bus.vld === 1'b1) begin
          m_l   = longint'($signed(bus.lft_chnnl));
          m_r   = longint'($signed(bus.rght_chnnl));
          m_res = isqrt((m_l * m_l + m_r * m_r) / 2);
          m_cnt = 1;
        end
      end else begin
        if (bus.vld === 1'b1) m_ovr = 1'b1;
        m_cnt++;
        if (m_cnt == 20) begin
          m_inten = m_res;
          if (m_res >= m_peak) begin
            m_peak = m_res;
            m_hold = 0;
          end else if (m_hold < int'(HOLD)) begin
            m_hold++;
          end else begin
            m_d = longint'(m_peak) >> DSH;
            if (m_d == 0) m_d = 1;
            m_peak = (longint'(m_peak) > m_d) ? 16'(longint'(m_peak) - m_d) : 16'd0;
          end
          m_led  = therm(m_peak);
          m_done = 1'b1;
          m_cnt  = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy",  32'(bus.busy),  32'(m_cnt != 0));
    chk("done",  32'(bus.done),  32'(m_done));
    chk("ovr",   32'(bus.ovr),   32'(m_ovr));
    chk("inten", 32'(bus.inten), 32'(m_inten));
    chk("peak",  32'(bus.peak),  32'(m_peak));
    chk("LED",   32'(bus.LED),   32'(m_led));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns negedges after the one following E0 (expect 19).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int lat);
    bus.vld = 1'b1; bus.lft_chnnl = l; bus.rght_chnnl = r;
    @(negedge clk);
    bus.vld = 1'b0;
    wait_done(lat);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rnd();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 3))
      0: v = v >> $urandom_range(0, 15);
      1: v = 16'h8000;
      2: v = v >> 4;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  int lat;
  int ovr_cnt;
  int n;
  logic saw_done;

  initial begin
    bus.vld = 1'b0; bus.lft_chnnl = '0; bus.rght_chnnl = '0;
    repeat (3) @(negedge clk);
    chk("rst_inten", 32'(bus.inten), 32'h0);
    chk("rst_LED",   32'(bus.LED),   32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h1000, 16'h1000, lat);
    chk("lat_1000",   32'(lat),       32'd19);
    chk("inten_1000", 32'(bus.inten), 32'h1000);
    chk("peak_1000",  32'(bus.peak),  32'h1000);
    chk("LED_1000",   32'(bus.LED),   32'hFF);

    send(16'h8000, 16'h8000, lat);
    chk("inten_8000", 32'(bus.inten), 32'h8000);
    chk("LED_8000",   32'(bus.LED),   32'hFF);

    do_reset();
    send(16'h0300, 16'h0000, lat);
    chk("inten_0300", 32'(bus.inten), 32'h021F);
    chk("LED_0300",   32'(bus.LED),   32'h03);
    send(16'hFD00, 16'h0000, lat);
    chk("inten_neg0300", 32'(bus.inten), 32'h021F);
    chk("LED_neg0300",   32'(bus.LED),   32'h03);

    do_reset();
    send(16'h1000, 16'h1000, lat);
    for (int i = 1; i <= 4; i++) begin
      send(16'h0, 16'h0, lat);
      chk("hold_peak", 32'(bus.peak), 32'h1000);
    end
    send(16'h0, 16'h0, lat);
    chk("decay1_peak", 32'(bus.peak), 32'h0E00);
    chk("decay1_LED",  32'(bus.LED),  32'h7F);
    send(16'h0, 16'h0, lat);
    chk("decay2_peak", 32'(bus.peak), 32'h0C40);
    n = 0;
    while (bus.peak != 16'd0 && n < 200) begin
      send(16'h0, 16'h0, lat);
      n++;
    end
    chk("decay_zero_peak", 32'(bus.peak), 32'h0);
    chk("decay_zero_LED",  32'(bus.LED),  32'h0);
    send(16'h0, 16'h0, lat);
    chk("no_underflow", 32'(bus.peak), 32'h0);

    // Overrun: extra vld at E5 and E19, then a legal one at E20.
    ovr_cnt = 0;
    bus.vld = 1'b1; bus.lft_chnnl = 16'h0300; bus.rght_chnnl = 16'h0000;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.ovr === 1'b1) ovr_cnt++;
      if (k == 20) begin
        chk("ovr_done",  32'(bus.done),  32'h1);
        chk("ovr_inten", 32'(bus.inten), 32'h021F);
      end
      bus.vld        = (k == 5 || k == 19 || k == 20);
      bus.lft_chnnl  = (k == 20) ? 16'h1000 : 16'h7777;
      bus.rght_chnnl = (k == 20) ? 16'h1000 : 16'h7777;
    end
    @(negedge clk);
    chk("ovr_e20", 32'(bus.ovr), 32'h0);
    chk("ovr_count", 32'(ovr_cnt), 32'd2);
    bus.vld = 1'b0;
    wait_done(lat);
    chk("e20_lat",   32'(lat),       32'd19);
    chk("e20_inten", 32'(bus.inten), 32'h1000);

    // Reset while in ROOT.
    bus.vld = 1'b1; bus.lft_chnnl = 16'h0300; bus.rght_chnnl = 16'h0300;
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_inten", 32'(bus.inten), 32'h0);
    chk("arst_peak",  32'(bus.peak),  32'h0);
    chk("arst_LED",   32'(bus.LED),   32'h0);
    chk("arst_busy",  32'(bus.busy),  32'h0);
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("arst_no_done", 32'(saw_done), 32'h0);
    send(16'h1000, 16'h1000, lat);
    chk("post_rst_lat",   32'(lat),       32'd19);
    chk("post_rst_inten", 32'(bus.inten), 32'h1000);

    // Random traffic, including held vld and overruns.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.vld && $urandom_range(0, 2) == 0) begin
        bus.vld = 1'b1;
      end else begin
        bus.vld = ($urandom_range(0, 11) == 0);
      end
      bus.lft_chnnl  = rnd();
      bus.rght_chnnl = rnd();
    end
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
